// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl_pkg: state type and reset values shared by the clock-gate controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REQ   = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_e;

    localparam logic RST_EN    = 1'b1;
    localparam logic RST_QREQ  = 1'b0;
    localparam logic RST_READY = 1'b1;

endpackage

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-hysteresis clock-gate enable with quiesce handshake and wake restore.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W = $clog2(IDLE_CYCLES > WAKE_CYCLES ? IDLE_CYCLES : WAKE_CYCLES) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cfg_enable_i,
    input  logic idle_i,
    input  logic wake_i,
    input  logic qaccept_i,
    input  logic test_en_i,
    output logic qreq_o,
    output logic en_o,
    output logic ready_o
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q;
    logic             q;

    assign q    = idle_i & ~wake_i & cfg_enable_i;
    assign en_o = en_q | test_en_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                state_d = (q && cnt_q == IDLE_LAST) ? REQ : RUN;
                cnt_d   = (q && cnt_q != IDLE_LAST) ? cnt_q + 1'b1 : '0;
            end
            REQ: state_d = !q ? RUN : (qaccept_i ? GATED : REQ);
            GATED: begin
                state_d = (wake_i || !cfg_enable_i) ? WAKE : GATED;
                cnt_d   = '0;
            end
            WAKE: begin
                // counter saturates while qaccept_i lingers; cleared on exit so RUN counts from 0
                state_d = (cnt_q == WAKE_LAST && !qaccept_i) ? RUN : WAKE;
                cnt_d   = (cnt_q == WAKE_LAST) ? (qaccept_i ? cnt_q : '0) : cnt_q + 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            en_q    <= RST_EN;
            qreq_o  <= RST_QREQ;
            ready_o <= RST_READY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= state_d != GATED;
            qreq_o  <= state_d == REQ || state_d == GATED;
            ready_o <= state_d == RUN || state_d == REQ;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: table vectors, hand sequences and a randomized run against a cycle-level reference model.
module tb_clk_gate_ctrl;
    import clk_gate_ctrl_pkg::*;

    localparam int IDLE_C = 16;
    localparam int WAKE_C = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_enable, idle, wake, qaccept, test_en;
    logic qreq, en, ready;

    int compared = 0;
    int mismatched = 0;

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE_C), .WAKE_CYCLES(WAKE_C)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_enable_i(cfg_enable), .idle_i(idle),
        .wake_i(wake), .qaccept_i(qaccept), .test_en_i(test_en),
        .qreq_o(qreq), .en_o(en), .ready_o(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: {en,qreq,ready} got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: mode plus idle streak length and cycles spent waking.
    state_e m_st;
    int     streak, age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st   <= RUN;
            streak <= 0;
            age    <= 0;
        end else begin
            case (m_st)
                RUN: begin
                    if (idle && !wake && cfg_enable) begin
                        if (streak + 1 == IDLE_C) begin
                            m_st   <= REQ;
                            streak <= 0;
                        end else streak <= streak + 1;
                    end else streak <= 0;
                end
                REQ: begin
                    if (!(idle && !wake && cfg_enable)) m_st <= RUN;
                    else if (qaccept) m_st <= GATED;
                end
                GATED: begin
                    if (wake || !cfg_enable) begin
                        m_st <= WAKE;
                        age  <= 0;
                    end
                end
                default: begin
                    age <= age + 1;
                    if (age + 1 >= WAKE_C && !qaccept) begin
                        m_st   <= RUN;
                        streak <= 0;
                    end
                end
            endcase
        end
    end

    logic prev_qreq = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            check("model", {en, qreq, ready},
                  {(m_st != GATED) || test_en, m_st == REQ || m_st == GATED, m_st == RUN || m_st == REQ});
            if (!en && (test_en || !qreq || ready))
                check("en_low_only_gated", {en, qreq, ready}, 3'b010);
            if (prev_qreq && !qreq && !dut.en_q)
                check("qreq_fall_while_gated", {dut.en_q, qreq, 1'b0}, 3'b100);
            prev_qreq <= qreq;
        end else prev_qreq <= 1'b0;
    end

    typedef struct {
        logic idle, wake, cfg, qacc, ten;
        int   n;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic i, input logic w, input logic c, input logic a, input logic t);
        idle = i; wake = w; cfg_enable = c; qaccept = a; test_en = t;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        vecs = '{
            '{1, 0, 1, 0, 0, 15, 3'b101},
            '{1, 0, 1, 0, 0,  1, 3'b111},
            '{1, 0, 1, 1, 0,  1, 3'b010},
            '{0, 0, 1, 1, 0,  3, 3'b010},
            '{0, 0, 1, 1, 1,  0, 3'b110},
            '{0, 0, 1, 1, 1,  2, 3'b110},
            '{0, 1, 1, 1, 0,  1, 3'b100},
            '{0, 0, 1, 1, 0,  4, 3'b100},
            '{0, 0, 1, 0, 0,  1, 3'b101},
            '{1, 0, 1, 0, 0, 16, 3'b111},
            '{1, 1, 1, 1, 0,  1, 3'b101},
            '{1, 0, 1, 0, 0, 16, 3'b111},
            '{1, 0, 1, 1, 0,  1, 3'b010},
            '{1, 0, 0, 1, 0,  1, 3'b100},
            '{1, 0, 1, 0, 0,  1, 3'b100},
            '{1, 0, 1, 0, 0,  1, 3'b101},
            '{0, 0, 0, 0, 0,  1, 3'b101}
        };
        rst = 1'b1;
        #1 check("reset_async", {en, qreq, ready}, 3'b101);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("reset_state", {en, qreq, ready}, 3'b101);

        foreach (vecs[k]) begin
            #1 drive(vecs[k].idle, vecs[k].wake, vecs[k].cfg, vecs[k].qacc, vecs[k].ten);
            if (vecs[k].n == 0) #1;
            else begin
                repeat (vecs[k].n) @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d", k), {en, qreq, ready}, vecs[k].exp);
        end

        // idle break: a single non-idle cycle restarts the full hysteresis
        #1 drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 check("break_pre", {en, qreq, ready}, 3'b101);
        end
        idle = 1'b0;
        @(posedge clk);
        #1 idle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 check(i == 15 ? "break_req" : "break_wait", {en, qreq, ready}, i == 15 ? 3'b111 : 3'b101);
        end

        // async reset landing mid-cycle while gated
        qaccept = 1'b1;
        @(posedge clk);
        #1 check("gated_before_rst", {en, qreq, ready}, 3'b010);
        #2 rst = 1'b1;
        #1 check("rst_mid_cycle", {en, qreq, ready}, 3'b101);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", {en, qreq, ready}, 3'b101);

        // randomized traffic alternating quiet and busy phases
        for (int c = 0; c < 3000; c++) begin
            automatic bit quiet = ((c / 40) % 3) != 0;
            @(posedge clk);
            #2;
            idle       = quiet ? ($urandom % 32 != 0) : ($urandom % 2 == 0);
            wake       = quiet ? ($urandom % 64 == 0) : ($urandom % 8 == 0);
            cfg_enable = quiet ? ($urandom % 64 != 0) : ($urandom % 4 != 0);
            qaccept    = ($urandom % 4 != 0) ? qreq : 1'($urandom % 2);
            test_en    = ($urandom % 16 == 0);
        end
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
